// File: rtl/captura_jogada.sv
// captura_jogada: play-capture front end for the ultimate tic-tac-toe board.
// Synchronises the raw buttons, filters bounce, rejects multi-button presses,
// latches the accepted press into the macro or micro one-hot register and
// offers its index through a valid/ack handshake. A full release is needed
// before the next play is taken.
// Build option: define CAPTURA_DEBOUNCE_EN to require DEBOUNCE_CYCLES extra
// stable cycles before a press is decided; without it the first nonzero
// synchronised sample is decided immediately.
module captura_jogada #(
    parameter int N_BOTOES        = 9,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int IDX_W           = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_BOTOES-1:0] botoes,
    input  logic                destino,
    input  logic                clear_macro,
    input  logic                clear_micro,
    input  logic                jogada_ack,
    output logic                jogada_valid,
    output logic [IDX_W-1:0]    posicao,
    output logic                erro_multiplo,
    output logic [N_BOTOES-1:0] leds,
    output logic [N_BOTOES-1:0] db_macro,
    output logic [N_BOTOES-1:0] db_micro,
    output logic [1:0]          db_estado
);

    if (DEBOUNCE_CYCLES < 1) begin : g_param_invalid
        $error("DEBOUNCE_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        OCIOSO     = 2'b00,
        ESTAVEL    = 2'b01,
        ESPERA_ACK = 2'b10,
        SOLTA      = 2'b11
    } estado_t;

    estado_t             estado, estado_next;
    logic [N_BOTOES-1:0] sync_p0, botoes_s;
    logic [N_BOTOES-1:0] cand;
    logic                aceita, rejeita;

`ifdef CAPTURA_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    logic [CNT_W-1:0]    cnt, cnt_next;
    logic [N_BOTOES-1:0] amostra, amostra_next;
`endif

    function automatic logic one_hot(input logic [N_BOTOES-1:0] v);
        return (v != '0) && ((v & (v - N_BOTOES'(1))) == '0);
    endfunction

    function automatic logic [IDX_W-1:0] indice(input logic [N_BOTOES-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_BOTOES; i++) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    // Two-flop synchroniser for the asynchronous buttons
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_p0  <= '0;
            botoes_s <= '0;
        end else begin
            sync_p0  <= botoes;
            botoes_s <= sync_p0;
        end
    end

    // State register plus debounce sample and counter
    always_ff @(posedge clock) begin
        if (reset) begin
            estado  <= OCIOSO;
`ifdef CAPTURA_DEBOUNCE_EN
            cnt     <= '0;
            amostra <= '0;
`endif
        end else begin
            estado  <= estado_next;
`ifdef CAPTURA_DEBOUNCE_EN
            cnt     <= cnt_next;
            amostra <= amostra_next;
`endif
        end
    end

    // Next-state logic and the accept/reject decision
    always_comb begin
        estado_next  = estado;
        aceita       = 1'b0;
        rejeita      = 1'b0;
        cand         = botoes_s;
`ifdef CAPTURA_DEBOUNCE_EN
        cnt_next     = cnt;
        amostra_next = amostra;
`endif
        case (estado)
            OCIOSO: begin
                if (botoes_s != '0) begin
`ifdef CAPTURA_DEBOUNCE_EN
                    amostra_next = botoes_s;
                    cnt_next     = '0;
                    estado_next  = ESTAVEL;
`else
                    if (one_hot(botoes_s)) begin
                        aceita      = 1'b1;
                        estado_next = ESPERA_ACK;
                    end else begin
                        rejeita     = 1'b1;
                        estado_next = SOLTA;
                    end
`endif
                end
            end
            ESTAVEL: begin
`ifdef CAPTURA_DEBOUNCE_EN
                cand = amostra;
                if (botoes_s != amostra) begin
                    estado_next = OCIOSO;
                end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    if (one_hot(amostra)) begin
                        aceita      = 1'b1;
                        estado_next = ESPERA_ACK;
                    end else begin
                        rejeita     = 1'b1;
                        estado_next = SOLTA;
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
`else
                estado_next = OCIOSO;
`endif
            end
            ESPERA_ACK: begin
                if (jogada_ack) estado_next = SOLTA;
            end
            SOLTA: begin
                if (botoes_s == '0) estado_next = OCIOSO;
            end
            default: estado_next = OCIOSO;
        endcase
    end

    // Handshake, index, error pulse and the one-hot play registers
    always_ff @(posedge clock) begin
        if (reset) begin
            jogada_valid  <= 1'b0;
            posicao       <= '0;
            erro_multiplo <= 1'b0;
            db_macro      <= '0;
            db_micro      <= '0;
        end else begin
            erro_multiplo <= rejeita;
            if (aceita) begin
                jogada_valid <= 1'b1;
                posicao      <= indice(cand);
            end else if (estado == ESPERA_ACK && jogada_ack) begin
                jogada_valid <= 1'b0;
            end
            if (clear_macro) db_macro <= '0;
            else if (aceita && !destino) db_macro <= cand;
            if (clear_micro) db_micro <= '0;
            else if (aceita && destino) db_micro <= cand;
        end
    end

    assign leds      = botoes_s;
    assign db_estado = estado;

endmodule

// File: tb/tb_captura_jogada.sv
// Testbench for captura_jogada: directed scenarios followed by a randomized
// phase, every cycle compared against a behavioural model of the play rules.
module tb_captura_jogada;

    localparam int N  = 9;
    localparam int DC = 4;
    localparam int IW = 4;
`ifdef CAPTURA_DEBOUNCE_EN
    localparam int NEED = DC + 1;   // sightings of the same value before a decision
    localparam int LAT  = DC + 3;
`else
    localparam int NEED = 1;
    localparam int LAT  = 3;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic [N-1:0]  botoes;
    logic          destino, clear_macro, clear_micro, jogada_ack;
    logic          jogada_valid, erro_multiplo;
    logic [IW-1:0] posicao;
    logic [N-1:0]  leds, db_macro, db_micro;
    logic [1:0]    db_estado;

    captura_jogada #(.N_BOTOES(N), .DEBOUNCE_CYCLES(DC), .IDX_W(IW)) dut (
        .clock(clock), .reset(reset), .botoes(botoes), .destino(destino),
        .clear_macro(clear_macro), .clear_micro(clear_micro),
        .jogada_ack(jogada_ack), .jogada_valid(jogada_valid),
        .posicao(posicao), .erro_multiplo(erro_multiplo), .leds(leds),
        .db_macro(db_macro), .db_micro(db_micro), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Behavioural model
    logic [N-1:0]  m_s1, m_s2, m_cand, m_macro, m_micro;
    int            m_run;
    bit            m_hold, m_rel, m_err;
    logic [IW-1:0] m_pos;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [N-1:0] s;
        bit wr;
        wr = 0;
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_cand = '0; m_macro = '0; m_micro = '0;
            m_run = 0; m_hold = 0; m_rel = 0; m_err = 0; m_pos = '0;
            return;
        end
        s = m_s2;
        m_s2 = m_s1;
        m_s1 = botoes;
        m_err = 0;
        if (m_hold) begin
            if (jogada_ack) begin m_hold = 0; m_rel = 1; end
        end else if (m_rel) begin
            if (s == '0) m_rel = 0;
        end else begin
            if (m_run == 0) begin
                if (s != '0) begin m_cand = s; m_run = 1; end
            end else if (s != m_cand) begin
                m_run = 0;
            end else begin
                m_run++;
            end
            if (m_run >= NEED) begin
                m_run = 0;
                if ($countones(m_cand) == 1) begin
                    m_hold = 1;
                    m_pos  = IW'($clog2(m_cand));
                    wr     = 1;
                end else begin
                    m_err = 1;
                    m_rel = 1;
                end
            end
        end
        if (clear_macro) m_macro = '0;
        else if (wr && !destino) m_macro = m_cand;
        if (clear_micro) m_micro = '0;
        else if (wr && destino) m_micro = m_cand;
    endtask

    task automatic check_all();
        logic [1:0] est;
        est = m_hold ? 2'b10 : m_rel ? 2'b11 : (m_run > 0) ? 2'b01 : 2'b00;
        chk("valid",    jogada_valid,  m_hold);
        chk("posicao",  posicao,       m_pos);
        chk("erro",     erro_multiplo, m_err);
        chk("leds",     leds,          m_s2);
        chk("db_macro", db_macro,      m_macro);
        chk("db_micro", db_micro,      m_micro);
        chk("estado",   db_estado,     est);
    endtask

    task automatic cycle();
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic ack_and_release();
        jogada_ack = 1'b1; cycle();
        jogada_ack = 1'b0; botoes = '0; cycles(4);
    endtask

    initial begin
        int n, errs;
        logic [N-1:0] v;
        reset = 1'b1; botoes = '0; destino = 1'b0; clear_macro = 1'b0;
        clear_micro = 1'b0; jogada_ack = 1'b0;
        cycles(2);
        chk("reset_valid", jogada_valid, 0);
        chk("reset_estado", db_estado, 0);
        reset = 1'b0;
        cycle();

        // Single press, latency, index and macro register
        botoes = 9'h010; destino = 1'b0;
        n = 0;
        while (!jogada_valid && n < 20) begin cycle(); n++; end
        chk("latency", n, LAT);
        chk("pos_4", posicao, 4);
        chk("macro_010", db_macro, 9'h010);
        cycles(3);
        jogada_ack = 1'b1; cycle();
        jogada_ack = 1'b0;
        chk("ack_drops_valid", jogada_valid, 0);
        botoes = '0; cycles(4);

        // Bouncing press, then stable
        for (int k = 0; k < 4; k++) begin
            botoes = 9'h001; cycles(2);
            botoes = '0;     cycles(2);
        end
        botoes = 9'h001; cycles(10);
        chk("bounce_valid", jogada_valid, 1);
        chk("bounce_pos", posicao, 0);
        ack_and_release();

        // Two buttons: one error pulse, no play, waits for release
        botoes = 9'h003; errs = 0;
        for (int k = 0; k < 12; k++) begin cycle(); if (erro_multiplo) errs++; end
        chk("err_pulses", errs, 1);
        chk("multi_no_valid", jogada_valid, 0);
        chk("multi_solta", db_estado, 2'b11);
        botoes = '0; cycles(4);

        // Held play ignores other buttons and destino changes
        botoes = 9'h100; destino = 1'b1; cycles(10);
        botoes = 9'h002; destino = 1'b0; cycles(8);
        chk("held_pos", posicao, 8);
        chk("micro_100", db_micro, 9'h100);
        jogada_ack = 1'b1; cycle();
        jogada_ack = 1'b0; botoes = '0; cycles(4);
        botoes = 9'h002; cycles(10);
        chk("next_pos", posicao, 1);
        ack_and_release();

        // Reset while a play is pending
        botoes = 9'h020; cycles(10);
        reset = 1'b1; cycle();
        chk("rst_valid", jogada_valid, 0);
        chk("rst_estado", db_estado, 0);
        chk("rst_macro", db_macro, 0);
        reset = 1'b0; botoes = '0; cycles(4);

        // Clear on the write edge wins
        botoes = 9'h008; destino = 1'b1; clear_micro = 1'b1; cycles(10);
        chk("clear_wins", db_micro, 0);
        chk("clear_valid", jogada_valid, 1);
        clear_micro = 1'b0;
        ack_and_release();

        // Randomized phase
        for (int seg = 0; seg < 80; seg++) begin
            int len, kind, a, b;
            len  = $urandom_range(1, 12);
            kind = $urandom_range(0, 3);
            a    = $urandom_range(0, N - 1);
            b    = (a + 1 + $urandom_range(0, N - 2)) % N;
            v    = '0;
            case (kind)
                1: v[a] = 1'b1;
                2: begin v[a] = 1'b1; v[b] = 1'b1; end
                3: v = N'($urandom);
                default: v = '0;
            endcase
            botoes = v;
            for (int k = 0; k < len; k++) begin
                jogada_ack  = ($urandom_range(0, 3) == 0);
                destino     = 1'($urandom_range(0, 1));
                clear_macro = ($urandom_range(0, 15) == 0);
                clear_micro = ($urandom_range(0, 15) == 0);
                reset       = ($urandom_range(0, 99) == 0);
                cycle();
            end
        end
        reset = 1'b0; jogada_ack = 1'b0; clear_macro = 1'b0; clear_micro = 1'b0;
        botoes = '0;
        cycles(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
